// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the memory arbiter slice.
package mem_arb_pkg;

    localparam int ADDR_W = 25;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        G_NONE,
        G_LD,
        G_FDD,
        G_CPU
    } grant_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Requester selection: loader first, then FDD, then CPU, except that a CPU
// passed over FDD_BURST times in a row wins over the FDD.
module mem_arb_pick
    import mem_arb_pkg::*;
#(
    parameter int FDD_BURST = 4,
    parameter int CNT_W     = 3
) (
    input  logic             i_ldReq,
    input  logic             i_fddReq,
    input  logic             i_cpuReq,
    input  logic [CNT_W-1:0] i_starveCnt,
    output logic [1:0]       o_grant
);

    logic   w_cpuStarved;
    grant_t w_grant;

    assign w_cpuStarved = (i_starveCnt >= CNT_W'(FDD_BURST));
    assign o_grant      = w_grant;

    // Fixed priority with the starvation override slotted between loader and FDD
    always_comb begin
        w_grant = G_NONE;
        if (i_ldReq) begin
            w_grant = G_LD;
        end else if (i_fddReq && !(i_cpuReq && w_cpuStarved)) begin
            w_grant = G_FDD;
        end else if (i_cpuReq) begin
            w_grant = G_CPU;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Three-port arbiter (loader, FDD buffer, CPU) in front of a single SDRAM
// controller port. One access at a time: IDLE -> ISSUE -> WAIT -> DONE.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT   = 63,
    parameter int FDD_BURST = 4
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              ld_req,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_din,
    output logic              ld_ack,
    input  logic              fdd_req,
    input  logic [ADDR_W-1:0] fdd_addr,
    output logic              fdd_ack,
    output logic [DATA_W-1:0] fdd_dout,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_din,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_dout,
    output logic              cpu_wait,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    output logic              mem_we,
    output logic              mem_rd,
    input  logic [DATA_W-1:0] mem_dout,
    input  logic              mem_ready,
    output logic              err
);

    localparam int CNT_W  = $clog2(FDD_BURST + 1);
    localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_t              r_state;
    grant_t              r_grant;
    logic                r_write;
    logic [CNT_W-1:0]    r_starveCnt;
    logic [WAIT_W-1:0]   r_waitCnt;
    logic [1:0]          w_pick;
    grant_t              w_grant;
    logic                w_timeout;
    logic [DATA_W-1:0]   w_rdData;

    mem_arb_pick #(
        .FDD_BURST (FDD_BURST),
        .CNT_W     (CNT_W)
    ) u_pick (
        .i_ldReq     (ld_req),
        .i_fddReq    (fdd_req),
        .i_cpuReq    (cpu_req),
        .i_starveCnt (r_starveCnt),
        .o_grant     (w_pick)
    );

    assign w_grant   = grant_t'(w_pick);
    assign w_timeout = (r_waitCnt == WAIT_W'(TIMEOUT - 1));
    assign w_rdData  = mem_ready ? mem_dout : 8'hFF;
    assign cpu_wait  = cpu_req & ~cpu_ack;

    // Access sequencer: latches the winner at grant, strobes once, waits for ready or timeout, acks
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_grant   <= G_NONE;
            r_write   <= 1'b0;
            r_waitCnt <= '0;
            mem_addr  <= '0;
            mem_din   <= '0;
            mem_we    <= 1'b0;
            mem_rd    <= 1'b0;
            ld_ack    <= 1'b0;
            fdd_ack   <= 1'b0;
            cpu_ack   <= 1'b0;
            fdd_dout  <= '0;
            cpu_dout  <= '0;
            err       <= 1'b0;
        end else begin
            mem_we  <= 1'b0;
            mem_rd  <= 1'b0;
            ld_ack  <= 1'b0;
            fdd_ack <= 1'b0;
            cpu_ack <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_waitCnt <= '0;
                    if (w_grant != G_NONE) begin
                        r_grant <= w_grant;
                        r_state <= S_ISSUE;
                        case (w_grant)
                            G_LD: begin
                                mem_addr <= ld_addr;
                                mem_din  <= ld_din;
                                r_write  <= 1'b1;
                                mem_we   <= 1'b1;
                            end
                            G_FDD: begin
                                mem_addr <= fdd_addr;
                                mem_din  <= '0;
                                r_write  <= 1'b0;
                                mem_rd   <= 1'b1;
                            end
                            default: begin
                                mem_addr <= cpu_addr;
                                mem_din  <= cpu_din;
                                r_write  <= cpu_we;
                                mem_we   <= cpu_we;
                                mem_rd   <= ~cpu_we;
                            end
                        endcase
                    end
                end
                S_ISSUE: begin
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (mem_ready || w_timeout) begin
                        r_state <= S_DONE;
                        if (!mem_ready) begin
                            err <= 1'b1;
                        end
                        case (r_grant)
                            G_LD: begin
                                ld_ack <= 1'b1;
                            end
                            G_FDD: begin
                                fdd_ack  <= 1'b1;
                                fdd_dout <= w_rdData;
                            end
                            G_CPU: begin
                                cpu_ack <= 1'b1;
                                if (!r_write) begin
                                    cpu_dout <= w_rdData;
                                end
                            end
                            default: begin
                            end
                        endcase
                    end else begin
                        r_waitCnt <= r_waitCnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Counts FDD wins that jumped a waiting CPU; cleared by a CPU win or an idle CPU
    always_ff @(posedge clk_sys) begin
        if (reset || !cpu_req) begin
            r_starveCnt <= '0;
        end else if (r_state == S_IDLE && w_grant == G_CPU) begin
            r_starveCnt <= '0;
        end else if (r_state == S_IDLE && w_grant == G_FDD &&
                     r_starveCnt < CNT_W'(FDD_BURST)) begin
            r_starveCnt <= r_starveCnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized
// multi-requester rounds checked against a transaction-level model.
module tb_mem_arbiter;

    localparam int TIMEOUT   = 63;
    localparam int FDD_BURST = 4;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        ld_req;
    logic [24:0] ld_addr;
    logic [7:0]  ld_din;
    logic        ld_ack;
    logic        fdd_req;
    logic [24:0] fdd_addr;
    logic        fdd_ack;
    logic [7:0]  fdd_dout;
    logic        cpu_req;
    logic        cpu_we;
    logic [24:0] cpu_addr;
    logic [7:0]  cpu_din;
    logic        cpu_ack;
    logic [7:0]  cpu_dout;
    logic        cpu_wait;
    logic [24:0] mem_addr;
    logic [7:0]  mem_din;
    logic        mem_we;
    logic        mem_rd;
    logic [7:0]  mem_dout;
    logic        mem_ready;
    logic        err;

    int compared   = 0;
    int mismatched = 0;

    logic [7:0]  mFddDout;
    logic [7:0]  mCpuDout;

    int          remain [3];
    logic [24:0] rAddr  [3];
    logic [7:0]  rDin   [3];
    logic        rWe    [3];

    mem_arbiter #(
        .TIMEOUT   (TIMEOUT),
        .FDD_BURST (FDD_BURST)
    ) dut (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .ld_req    (ld_req),
        .ld_addr   (ld_addr),
        .ld_din    (ld_din),
        .ld_ack    (ld_ack),
        .fdd_req   (fdd_req),
        .fdd_addr  (fdd_addr),
        .fdd_ack   (fdd_ack),
        .fdd_dout  (fdd_dout),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_din   (cpu_din),
        .cpu_ack   (cpu_ack),
        .cpu_dout  (cpu_dout),
        .cpu_wait  (cpu_wait),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .mem_we    (mem_we),
        .mem_rd    (mem_rd),
        .mem_dout  (mem_dout),
        .mem_ready (mem_ready),
        .err       (err)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic clearInputs();
        ld_req    = 1'b0;
        ld_addr   = '0;
        ld_din    = '0;
        fdd_req   = 1'b0;
        fdd_addr  = '0;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = '0;
        cpu_din   = '0;
        mem_dout  = '0;
        mem_ready = 1'b0;
    endtask

    task automatic newReq(input int k);
        rAddr[k] = 25'($urandom);
        rDin[k]  = 8'($urandom);
        rWe[k]   = (k == 0) ? 1'b1 : (k == 1) ? 1'b0 : 1'($urandom_range(0, 1));
    endtask

    task automatic driveReqs();
        ld_req   = (remain[0] > 0);
        ld_addr  = rAddr[0];
        ld_din   = rDin[0];
        fdd_req  = (remain[1] > 0);
        fdd_addr = rAddr[1];
        cpu_req  = (remain[2] > 0);
        cpu_addr = rAddr[2];
        cpu_din  = rDin[2];
        cpu_we   = rWe[2];
    endtask

    task automatic test_reset();
        clearInputs();
        reset = 1'b1;
        repeat (2) @(negedge clk_sys);
        mFddDout = 8'h00;
        mCpuDout = 8'h00;
        compared++;
        if ({ld_ack, fdd_ack, cpu_ack} !== 3'b000) begin
            mismatched++;
            $display("[TB] FAIL reset_acks got=%b want=000", {ld_ack, fdd_ack, cpu_ack});
        end
        compared++;
        if ({mem_we, mem_rd, err} !== 3'b000) begin
            mismatched++;
            $display("[TB] FAIL reset_strobe_err got=%b want=000", {mem_we, mem_rd, err});
        end
        compared++;
        if ({fdd_dout, cpu_dout} !== 16'h0000) begin
            mismatched++;
            $display("[TB] FAIL reset_dout got=%h want=0000", {fdd_dout, cpu_dout});
        end
        compared++;
        if ({mem_addr, mem_din} !== 33'h0) begin
            mismatched++;
            $display("[TB] FAIL reset_addr_din got=%h want=0", {mem_addr, mem_din});
        end
        reset = 1'b0;
        mem_ready = 1'b1;
        mem_dout  = 8'hC3;
        repeat (2) @(negedge clk_sys);
        compared++;
        if ({ld_ack, fdd_ack, cpu_ack, mem_we, mem_rd, cpu_wait} !== 6'b0) begin
            mismatched++;
            $display("[TB] FAIL idle_quiet got=%b want=000000",
                     {ld_ack, fdd_ack, cpu_ack, mem_we, mem_rd, cpu_wait});
        end
        mem_ready = 1'b0;
    endtask

    task automatic test_cpu_read();
        int rdCount  = 0;
        int ackCount = 0;
        int ackAt    = -1;
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 25'h0C000;
        cpu_din  = 8'h55;
        for (int t = 1; t <= 6; t++) begin
            @(negedge clk_sys);
            if (mem_rd) rdCount++;
            if (mem_we) rdCount += 100;
            if (cpu_ack) begin
                ackCount++;
                if (ackAt < 0) ackAt = t;
            end
            if (t == 1) begin
                compared++;
                if (mem_addr !== 25'h0C000) begin
                    mismatched++;
                    $display("[TB] FAIL cpu_read_addr got=%h want=0c000", mem_addr);
                end
            end
            if (t == 2) begin
                compared++;
                if (cpu_wait !== 1'b1) begin
                    mismatched++;
                    $display("[TB] FAIL cpu_read_wait got=%b want=1", cpu_wait);
                end
            end
            if (t == 3) begin
                compared++;
                if (cpu_dout !== 8'h3E) begin
                    mismatched++;
                    $display("[TB] FAIL cpu_read_dout got=%h want=3e", cpu_dout);
                end
                compared++;
                if (cpu_wait !== 1'b0) begin
                    mismatched++;
                    $display("[TB] FAIL cpu_read_wait_at_ack got=%b want=0", cpu_wait);
                end
                cpu_req = 1'b0;
            end
            mem_ready = (t == 2);
            mem_dout  = (t == 2) ? 8'h3E : 8'h00;
        end
        mCpuDout = 8'h3E;
        compared++;
        if (ackAt != 3 || ackCount != 1) begin
            mismatched++;
            $display("[TB] FAIL cpu_read_ack_timing got=t%0d x%0d want=t3 x1", ackAt, ackCount);
        end
        compared++;
        if (rdCount != 1) begin
            mismatched++;
            $display("[TB] FAIL cpu_read_strobes got=%0d want=1", rdCount);
        end
    endtask

    task automatic test_random(input int rounds);
        int         starve;
        int         t;
        int         strobeDue;
        int         ackDue;
        int         readyAt;
        int         sTime;
        int         g;
        int         dly;
        bit         busy;
        logic [7:0] rdData;
        logic [1:0] expStrobe;
        logic [2:0] expAck;
        for (int r = 0; r < rounds; r++) begin
            if (r == 0) begin
                remain = '{1, 1, 1};
            end else begin
                do begin
                    remain[0] = $urandom_range(0, 2);
                    remain[1] = $urandom_range(0, 6);
                    remain[2] = $urandom_range(0, 2);
                end while (remain[0] + remain[1] + remain[2] == 0);
            end
            for (int k = 0; k < 3; k++) newReq(k);
            driveReqs();
            starve    = 0;
            strobeDue = 1;
            ackDue    = -1;
            readyAt   = -1;
            sTime     = -1;
            g         = -1;
            busy      = 1'b1;
            rdData    = 8'h00;
            t         = 0;
            while (busy && t < 400) begin
                @(negedge clk_sys);
                t++;
                expStrobe = 2'b00;
                expAck    = 3'b000;
                if (t == strobeDue) begin
                    if (remain[0] > 0) g = 0;
                    else if (remain[1] > 0 && !(remain[2] > 0 && starve >= FDD_BURST)) g = 1;
                    else g = 2;
                    if (g == 1 && remain[2] > 0) starve++;
                    if (g == 2) starve = 0;
                    dly       = $urandom_range(0, 4);
                    sTime     = t;
                    readyAt   = t + 1 + dly;
                    ackDue    = t + 2 + dly;
                    rdData    = 8'($urandom);
                    expStrobe = rWe[g] ? 2'b10 : 2'b01;
                end
                if (t == ackDue) expAck = 3'b100 >> g;
                compared++;
                if ({mem_we, mem_rd} !== expStrobe) begin
                    mismatched++;
                    $display("[TB] FAIL rand_strobe r=%0d t=%0d got=%b want=%b",
                             r, t, {mem_we, mem_rd}, expStrobe);
                end
                compared++;
                if ({ld_ack, fdd_ack, cpu_ack} !== expAck) begin
                    mismatched++;
                    $display("[TB] FAIL rand_ack r=%0d t=%0d got=%b want=%b",
                             r, t, {ld_ack, fdd_ack, cpu_ack}, expAck);
                end
                compared++;
                if (cpu_wait !== (cpu_req & ~expAck[0])) begin
                    mismatched++;
                    $display("[TB] FAIL rand_cpu_wait r=%0d t=%0d got=%b want=%b",
                             r, t, cpu_wait, cpu_req & ~expAck[0]);
                end
                if (g >= 0 && t >= sTime && t <= ackDue) begin
                    compared++;
                    if (mem_addr !== rAddr[g]) begin
                        mismatched++;
                        $display("[TB] FAIL rand_addr r=%0d t=%0d got=%h want=%h",
                                 r, t, mem_addr, rAddr[g]);
                    end
                    if (rWe[g]) begin
                        compared++;
                        if (mem_din !== rDin[g]) begin
                            mismatched++;
                            $display("[TB] FAIL rand_din r=%0d t=%0d got=%h want=%h",
                                     r, t, mem_din, rDin[g]);
                        end
                    end
                end
                if (t == ackDue) begin
                    if (!rWe[g]) begin
                        if (g == 1) mFddDout = rdData;
                        else mCpuDout = rdData;
                    end
                    compared++;
                    if (fdd_dout !== mFddDout) begin
                        mismatched++;
                        $display("[TB] FAIL rand_fdd_dout r=%0d t=%0d got=%h want=%h",
                                 r, t, fdd_dout, mFddDout);
                    end
                    compared++;
                    if (cpu_dout !== mCpuDout) begin
                        mismatched++;
                        $display("[TB] FAIL rand_cpu_dout r=%0d t=%0d got=%h want=%h",
                                 r, t, cpu_dout, mCpuDout);
                    end
                    remain[g]--;
                    if (remain[g] > 0) newReq(g);
                    if (remain[2] == 0) starve = 0;
                    driveReqs();
                    if (remain[0] + remain[1] + remain[2] > 0) strobeDue = t + 2;
                    else busy = 1'b0;
                end
                if (t == readyAt) begin
                    mem_ready = 1'b1;
                    mem_dout  = rdData;
                end else if (g >= 0 && t > sTime && t < readyAt) begin
                    mem_ready = 1'b0;
                    mem_dout  = 8'($urandom);
                end else begin
                    mem_ready = 1'($urandom_range(0, 1));
                    mem_dout  = 8'($urandom);
                end
            end
            if (busy) begin
                mismatched++;
                $display("[TB] FAIL rand_round_timeout r=%0d", r);
                clearInputs();
                reset = 1'b1;
                @(negedge clk_sys);
                reset = 1'b0;
                mFddDout = 8'h00;
                mCpuDout = 8'h00;
            end
            repeat (2) @(negedge clk_sys);
            mem_ready = 1'b0;
            compared++;
            if (err !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL rand_err r=%0d got=%b want=0", r, err);
            end
        end
    endtask

    task automatic test_starvation();
        int         fddGrants = 0;
        int         fddBefore = -1;
        int         t         = 0;
        bit         cpuDone   = 1'b0;
        bit         prev      = 1'b0;
        logic [7:0] lastData  = 8'h00;
        fdd_req  = 1'b1;
        fdd_addr = 25'h0001;
        cpu_req  = 1'b1;
        cpu_we   = 1'b1;
        cpu_addr = 25'h0002;
        cpu_din  = 8'hA5;
        while (!cpuDone && t < 200) begin
            @(negedge clk_sys);
            t++;
            if (mem_rd) fddGrants++;
            if (mem_we && fddBefore < 0) fddBefore = fddGrants;
            if (fdd_ack) begin
                mFddDout = lastData;
                compared++;
                if (fdd_dout !== mFddDout) begin
                    mismatched++;
                    $display("[TB] FAIL starve_fdd_dout got=%h want=%h", fdd_dout, mFddDout);
                end
            end
            if (cpu_ack) begin
                compared++;
                if (cpu_dout !== mCpuDout) begin
                    mismatched++;
                    $display("[TB] FAIL starve_cpu_write_dout got=%h want=%h", cpu_dout, mCpuDout);
                end
                cpu_req = 1'b0;
                fdd_req = 1'b0;
                cpuDone = 1'b1;
            end
            mem_ready = prev;
            if (prev) begin
                lastData = 8'($urandom);
                mem_dout = lastData;
            end
            prev = mem_rd | mem_we;
        end
        compared++;
        if (!cpuDone || fddBefore != FDD_BURST) begin
            mismatched++;
            $display("[TB] FAIL starve_fdd_before_cpu got=%0d want=%0d done=%0d",
                     fddBefore, FDD_BURST, cpuDone);
        end
        clearInputs();
        repeat (2) @(negedge clk_sys);
    endtask

    task automatic test_timeout();
        int t     = 0;
        int sT    = -1;
        int ackT  = -1;
        bit got   = 1'b0;
        bit prev  = 1'b0;
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 25'h00155;
        mem_ready = 1'b0;
        while (ackT < 0 && t < 150) begin
            @(negedge clk_sys);
            t++;
            if (mem_rd && sT < 0) sT = t;
            if (cpu_ack) begin
                ackT = t;
                cpu_req = 1'b0;
                compared++;
                if (cpu_dout !== 8'hFF) begin
                    mismatched++;
                    $display("[TB] FAIL timeout_dout got=%h want=ff", cpu_dout);
                end
                compared++;
                if (err !== 1'b1) begin
                    mismatched++;
                    $display("[TB] FAIL timeout_err got=%b want=1", err);
                end
            end
            mem_dout = 8'($urandom);
        end
        mCpuDout = 8'hFF;
        compared++;
        if (ackT < 0 || sT != 1 || ackT - sT != TIMEOUT + 1) begin
            mismatched++;
            $display("[TB] FAIL timeout_latency got=issue t%0d ack t%0d want=issue t1 ack t%0d",
                     sT, ackT, TIMEOUT + 2);
        end
        ld_req  = 1'b1;
        ld_addr = 25'h0ABCD;
        ld_din  = 8'h77;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk_sys);
            mem_ready = prev;
            prev = mem_rd | mem_we;
            if (ld_ack) begin
                ld_req = 1'b0;
                got = 1'b1;
            end
        end
        compared++;
        if (!got) begin
            mismatched++;
            $display("[TB] FAIL timeout_followup_ack got=0 want=1");
        end
        compared++;
        if (err !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL err_sticky got=%b want=1", err);
        end
        clearInputs();
    endtask

    task automatic test_reset_in_wait();
        int  ackAt = -1;
        int  spur  = 0;
        bit  prev  = 1'b0;
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 25'h00777;
        mem_ready = 1'b0;
        repeat (3) @(negedge clk_sys);
        reset   = 1'b1;
        cpu_req = 1'b0;
        @(negedge clk_sys);
        reset = 1'b0;
        mFddDout = 8'h00;
        mCpuDout = 8'h00;
        compared++;
        if ({ld_ack, fdd_ack, cpu_ack, mem_we, mem_rd, err} !== 6'b0) begin
            mismatched++;
            $display("[TB] FAIL wait_reset_ctrl got=%b want=000000",
                     {ld_ack, fdd_ack, cpu_ack, mem_we, mem_rd, err});
        end
        compared++;
        if ({fdd_dout, cpu_dout, mem_addr, mem_din} !== 49'h0) begin
            mismatched++;
            $display("[TB] FAIL wait_reset_data got=%h want=0",
                     {fdd_dout, cpu_dout, mem_addr, mem_din});
        end
        mem_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_sys);
            if ({ld_ack, fdd_ack, cpu_ack, mem_we, mem_rd} !== 5'b0) spur++;
        end
        compared++;
        if (spur != 0) begin
            mismatched++;
            $display("[TB] FAIL wait_reset_no_ack got=%0d want=0", spur);
        end
        mem_ready = 1'b0;
        cpu_req  = 1'b1;
        cpu_addr = 25'h00123;
        for (int t = 1; t <= 6; t++) begin
            @(negedge clk_sys);
            if (cpu_ack && ackAt < 0) begin
                ackAt = t;
                cpu_req = 1'b0;
                compared++;
                if (cpu_dout !== 8'h5A) begin
                    mismatched++;
                    $display("[TB] FAIL after_reset_dout got=%h want=5a", cpu_dout);
                end
            end
            mem_ready = prev;
            mem_dout  = prev ? 8'h5A : 8'h00;
            prev = mem_rd | mem_we;
        end
        compared++;
        if (ackAt != 3) begin
            mismatched++;
            $display("[TB] FAIL after_reset_ack_cycle got=t%0d want=t3", ackAt);
        end
        clearInputs();
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        clearInputs();
        reset = 1'b1;
        test_reset();
        test_cpu_read();
        test_random(40);
        test_starvation();
        test_timeout();
        test_reset_in_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 63, meaning the maximum number of WAIT cycles before an access is aborted.
REQ-002 SHALL have parameter FDD_BURST, default 4, meaning the maximum number of consecutive FDD grants allowed while a CPU request is pending.
REQ-003 SHALL have ports (one per line):
clk_sys  in  1  system clock; all logic on its rising edge
reset  in  1  synchronous, active-high
ld_req  in  1  loader write request (level)
ld_addr  in  25  loader address
ld_din  in  8  loader write data
ld_ack  out  1  one-cycle completion pulse
fdd_req  in  1  FDD buffer read request (level)
fdd_addr  in  25  FDD read address
fdd_ack  out  1  one-cycle completion pulse
fdd_dout  out  8  FDD read data
cpu_req  in  1  CPU request (level)
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  25  CPU address
cpu_din  in  8  CPU write data
cpu_ack  out  1  one-cycle completion pulse
cpu_dout  out  8  CPU read data
cpu_wait  out  1  high while cpu_req is pending and not yet acknowledged
mem_addr  out  25  SDRAM-controller address
mem_din  out  8  SDRAM-controller write data
mem_we  out  1  one-cycle write strobe
mem_rd  out  1  one-cycle read strobe
mem_dout  in  8  SDRAM-controller read data
mem_ready  in  1  SDRAM-controller access complete
err  out  1  sticky timeout flag

Function
REQ-004 SHALL implement FSM IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
REQ-005 IDLE SHALL select a requester from those asserting req, then move to ISSUE; it SHALL stay in IDLE when no req is asserted.
REQ-006 Priority SHALL be loader > FDD > CPU, except as overridden by REQ-007.
REQ-007 The starvation counter SHALL increment on each FDD grant made while cpu_req is high, and SHALL clear on any CPU grant or whenever cpu_req is low; at FDD_BURST the CPU SHALL win over FDD.
REQ-008 At grant SHALL register address, data, direction and the granted requester; later changes on the request inputs SHALL NOT affect the access in flight.
REQ-009 ISSUE SHALL assert exactly one of mem_we or mem_rd for one cycle; loader accesses are writes, FDD accesses are reads, CPU direction follows cpu_we.
REQ-010 mem_addr and mem_din SHALL be held stable from ISSUE through DONE.
REQ-011 WAIT SHALL exit to DONE on the first cycle mem_ready=1; read data SHALL be captured from mem_dout in that cycle.
REQ-012 If mem_ready has not been seen after TIMEOUT WAIT cycles, the FSM SHALL go to DONE with read data 8'hFF and set err.
REQ-013 DONE SHALL pulse the granted requester's ack for one cycle, with its dout already valid.
REQ-014 Each dout SHALL hold its value until that port's next read ack; a CPU write SHALL leave cpu_dout unchanged.
REQ-015 Minimum request-to-ack latency SHALL be 4 cycles (IDLE, ISSUE, WAIT with mem_ready=1, DONE).
REQ-016 A requester SHALL drop req in the cycle after its ack; a request held through the following IDLE cycle is treated as a new request.
REQ-017 cpu_wait SHALL be combinational: cpu_req & ~cpu_ack.
REQ-018 Requests arriving during ISSUE, WAIT or DONE SHALL wait for the next IDLE; no request SHALL be lost.
REQ-019 mem_ready asserted outside WAIT SHALL be ignored.

Reset
REQ-020 On reset the FSM SHALL go to IDLE at the next edge, aborting any access in flight without issuing an ack.
REQ-021 On reset all acks, mem_we, mem_rd, err, the starvation counter, fdd_dout, cpu_dout, mem_addr and mem_din SHALL be 0.

Structure
REQ-022 Package mem_arb_pkg SHALL hold the FSM state enum, the grant enum (NONE/LD/FDD/CPU), and the address (25) and data (8) width constants.
REQ-023 The priority and starvation selection SHALL be a sub-module, mem_arb_pick.

Verification
REQ-024 cpu_req read of addr 0x0C000 with mem_ready on the first WAIT cycle and mem_dout=0x3E -> cpu_ack at cycle 4, cpu_dout=0x3E, mem_rd pulsed once.
REQ-025 ld_req, fdd_req and cpu_req asserted in the same cycle -> grant order LD, FDD, CPU; each ack is a single pulse.
REQ-026 fdd_req held continuously with cpu_req pending -> CPU granted after exactly 4 FDD grants.
REQ-027 mem_ready held low -> ack after 63 WAIT cycles, dout=0xFF, err=1 and stays 1 until reset.
REQ-028 reset asserted during WAIT -> IDLE next cycle, no ack, all outputs 0; a later request completes normally.
